// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_arbiter.
// slave: arbiter view; master: environment (requesters + memory) view.
interface mem_arbiter_if #(
    parameter int unsigned M = 16,
    parameter int unsigned N = 32
) ();
    logic         req0;
    logic         req1;
    logic [N-1:0] addr0;
    logic [N-1:0] addr1;
    logic [M-1:0] wdata0;
    logic [M-1:0] wdata1;
    logic         we0;
    logic         we1;
    logic         ack0;
    logic         ack1;
    logic         err;
    logic [M-1:0] rdata;
    logic [N-1:0] memAddr;
    logic [M-1:0] memWrite;
    logic         memRE;
    logic         memWE;
    logic [M-1:0] memRead;
    logic         memAck;

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, memRead, memAck,
        output ack0, ack1, err, rdata, memAddr, memWrite, memRE, memWE
    );

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, memRead, memAck,
        input  ack0, ack1, err, rdata, memAddr, memWrite, memRE, memWE
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with per-access timeout; all outputs registered.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention, else requester 0 has fixed priority.
module mem_arbiter #(
    parameter int unsigned M       = 16,
    parameter int unsigned N       = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    // Counter value at which the current BUSY cycle is the TIMEOUT-th one.
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         owner_q, owner_d;
    logic [N-1:0] mem_addr_q, mem_addr_d;
    logic [M-1:0] mem_write_q, mem_write_d;
    logic         mem_re_q, mem_re_d;
    logic         mem_we_q, mem_we_d;
    logic [M-1:0] rdata_q, rdata_d;
    logic         ack0_q, ack0_d;
    logic         ack1_q, ack1_d;
    logic         err_q, err_d;
    logic         grant1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    // On contention, the requester that did not own the bus last wins.
    assign grant1 = bus.req1 & (~bus.req0 | ~last_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == StIdle && (bus.req0 || bus.req1)) begin
            last_d = grant1;
        end
    end
`else
    assign grant1 = bus.req1 & ~bus.req0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        mem_addr_d  = mem_addr_q;
        mem_write_d = mem_write_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        rdata_d     = rdata_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    owner_d     = grant1;
                    mem_addr_d  = grant1 ? bus.addr1 : bus.addr0;
                    mem_write_d = grant1 ? bus.wdata1 : bus.wdata0;
                    mem_we_d    = grant1 ? bus.we1 : bus.we0;
                    mem_re_d    = grant1 ? ~bus.we1 : ~bus.we0;
                    cnt_d       = '0;
                    state_d     = StBusy;
                end
            end
            StBusy: begin
                if (bus.memAck || cnt_q == CntLast) begin
                    state_d  = StDone;
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                    ack0_d   = ~owner_q;
                    ack1_d   = owner_q;
                    // memAck wins over a timeout landing in the same cycle.
                    if (bus.memAck) begin
                        if (mem_re_q) begin
                            rdata_d = bus.memRead;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_write_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            rdata_q     <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            rdata_q     <= rdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err_q       <= err_d;
        end
    end

    assign bus.memAddr  = mem_addr_q;
    assign bus.memWrite = mem_write_q;
    assign bus.memRE    = mem_re_q;
    assign bus.memWE    = mem_we_q;
    assign bus.rdata    = rdata_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + random self-checking bench for mem_arbiter (TIMEOUT=4).
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.M(16), .N(32)) mem_if ();

    mem_arbiter #(.M(16), .N(32), .TIMEOUT(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (mem_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int viol, spurious, raised0, raised1, acked0, acked1;

    task automatic rand_step(input bit allow_raise);
        tick;
        if (mem_if.ack0 && mem_if.ack1) viol++;
        if (mem_if.memRE && mem_if.memWE) viol++;
        if (mem_if.err && !(mem_if.ack0 || mem_if.ack1)) viol++;
        if (mem_if.ack0) begin
            if (!mem_if.req0) spurious++;
            acked0++;
            mem_if.req0 = 1'b0;
        end else if (allow_raise && !mem_if.req0 && $urandom_range(3) == 0) begin
            mem_if.req0   = 1'b1;
            mem_if.we0    = 1'($urandom_range(1));
            mem_if.addr0  = $urandom;
            mem_if.wdata0 = 16'($urandom);
            raised0++;
        end
        if (mem_if.ack1) begin
            if (!mem_if.req1) spurious++;
            acked1++;
            mem_if.req1 = 1'b0;
        end else if (allow_raise && !mem_if.req1 && $urandom_range(3) == 0) begin
            mem_if.req1   = 1'b1;
            mem_if.we1    = 1'($urandom_range(1));
            mem_if.addr1  = $urandom;
            mem_if.wdata1 = 16'($urandom);
            raised1++;
        end
        mem_if.memAck  = ($urandom_range(2) == 0);
        mem_if.memRead = 16'($urandom);
    endtask

    initial begin
        int g;
        int n;
        int exp_g;

        mem_if.req0 = 0; mem_if.req1 = 0; mem_if.we0 = 0; mem_if.we1 = 0;
        mem_if.addr0 = '0; mem_if.addr1 = '0; mem_if.wdata0 = '0; mem_if.wdata1 = '0;
        mem_if.memAck = 0; mem_if.memRead = '0;
        viol = 0; spurious = 0; raised0 = 0; raised1 = 0; acked0 = 0; acked1 = 0;

        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        check("rst_ack0", 32'(mem_if.ack0), 0);
        check("rst_ack1", 32'(mem_if.ack1), 0);
        check("rst_err", 32'(mem_if.err), 0);
        check("rst_memre", 32'(mem_if.memRE), 0);
        check("rst_memwe", 32'(mem_if.memWE), 0);
        check("rst_memaddr", mem_if.memAddr, 0);
        check("rst_memwrite", 32'(mem_if.memWrite), 0);
        check("rst_rdata", 32'(mem_if.rdata), 0);

        // Read, memAck in 2nd BUSY cycle
        mem_if.req0 = 1; mem_if.we0 = 0; mem_if.addr0 = 32'h0000_1234;
        tick;
        check("rd_re1", 32'(mem_if.memRE), 1);
        check("rd_we1", 32'(mem_if.memWE), 0);
        check("rd_addr", mem_if.memAddr, 32'h0000_1234);
        tick;
        check("rd_re2", 32'(mem_if.memRE), 1);
        mem_if.memAck = 1; mem_if.memRead = 16'hBEEF;
        tick;
        check("rd_ack0", 32'(mem_if.ack0), 1);
        check("rd_ack1", 32'(mem_if.ack1), 0);
        check("rd_rdata", 32'(mem_if.rdata), 32'hBEEF);
        check("rd_err", 32'(mem_if.err), 0);
        check("rd_re_drop", 32'(mem_if.memRE), 0);
        mem_if.req0 = 0; mem_if.memAck = 0;
        tick;
        check("rd_ack_pulse", 32'(mem_if.ack0), 0);

        // Write, memAck in 1st BUSY cycle
        mem_if.req1 = 1; mem_if.we1 = 1; mem_if.addr1 = 32'h0000_D000; mem_if.wdata1 = 16'h5A5A;
        mem_if.memRead = 16'h1111;
        tick;
        check("wr_we", 32'(mem_if.memWE), 1);
        check("wr_re", 32'(mem_if.memRE), 0);
        check("wr_data", 32'(mem_if.memWrite), 32'h5A5A);
        check("wr_addr", mem_if.memAddr, 32'h0000_D000);
        mem_if.memAck = 1;
        tick;
        check("wr_ack1", 32'(mem_if.ack1), 1);
        check("wr_ack0", 32'(mem_if.ack0), 0);
        check("wr_we_drop", 32'(mem_if.memWE), 0);
        check("wr_rdata_keep", 32'(mem_if.rdata), 32'hBEEF);
        mem_if.req1 = 0; mem_if.memAck = 0;
        tick;
        check("wr_ack_pulse", 32'(mem_if.ack1), 0);

        // Contention: both held for 4 accesses
        mem_if.req0 = 1; mem_if.we0 = 0; mem_if.addr0 = 32'h100;
        mem_if.req1 = 1; mem_if.we1 = 0; mem_if.addr1 = 32'h200;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            tick;
            while (!(mem_if.memRE || mem_if.memWE) && n < 5) begin
                tick;
                n++;
            end
            check("cont_strobe", 32'(mem_if.memRE), 1);
            g = (mem_if.memAddr == 32'h200) ? 1 : 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_g = i % 2;
`else
            exp_g = 0;
`endif
            check("cont_grant", 32'(g), 32'(exp_g));
            mem_if.memAck = 1;
            tick;
            check("cont_ack", 32'(g == 1 ? mem_if.ack1 : mem_if.ack0), 1);
            check("cont_ack_onehot", 32'(mem_if.ack0 & mem_if.ack1), 0);
            mem_if.memAck = 0;
            if (i == 3) begin
                mem_if.req0 = 0;
                mem_if.req1 = 0;
            end
        end
        tick;

        // Single requester 1 after history
        mem_if.req1 = 1; mem_if.we1 = 0; mem_if.addr1 = 32'h300;
        tick;
        check("single_addr", mem_if.memAddr, 32'h300);
        mem_if.memAck = 1; mem_if.memRead = 16'hA5A5;
        tick;
        check("single_ack1", 32'(mem_if.ack1), 1);
        check("single_rdata", 32'(mem_if.rdata), 32'hA5A5);
        mem_if.req1 = 0; mem_if.memAck = 0;
        tick;

        // Timeout with TIMEOUT=4
        mem_if.req0 = 1; mem_if.we0 = 0; mem_if.addr0 = 32'h42;
        tick;
        n = 0;
        while (mem_if.memRE && n < 20) begin
            n++;
            tick;
        end
        check("to_cycles", 32'(n), 4);
        check("to_ack0", 32'(mem_if.ack0), 1);
        check("to_err", 32'(mem_if.err), 1);
        check("to_rdata_keep", 32'(mem_if.rdata), 32'hA5A5);
        mem_if.req0 = 0;
        tick;
        check("to_err_pulse", 32'(mem_if.err), 0);

        // memAck on the last allowed BUSY cycle completes normally
        mem_if.req0 = 1; mem_if.addr0 = 32'h44;
        tick; tick; tick; tick;
        check("late_re", 32'(mem_if.memRE), 1);
        mem_if.memAck = 1; mem_if.memRead = 16'h1357;
        tick;
        check("late_ack0", 32'(mem_if.ack0), 1);
        check("late_err", 32'(mem_if.err), 0);
        check("late_rdata", 32'(mem_if.rdata), 32'h1357);
        mem_if.req0 = 0; mem_if.memAck = 0;
        tick;

        // Reset in 2nd BUSY cycle
        mem_if.req0 = 1; mem_if.addr0 = 32'h77; mem_if.we0 = 0;
        tick; tick;
        check("mr_busy", 32'(mem_if.memRE), 1);
        rst = 1;
        tick;
        rst = 0;
        check("mr_re", 32'(mem_if.memRE), 0);
        check("mr_ack0", 32'(mem_if.ack0), 0);
        check("mr_err", 32'(mem_if.err), 0);
        check("mr_addr", mem_if.memAddr, 0);
        check("mr_rdata", 32'(mem_if.rdata), 0);
        tick;
        check("mr_ack0_after", 32'(mem_if.ack0), 0);
        check("mr_regrant", mem_if.memAddr, 32'h77);
        mem_if.memAck = 1;
        tick;
        check("mr_regrant_ack", 32'(mem_if.ack0), 1);
        mem_if.req0 = 0; mem_if.memAck = 0;
        tick;

        // Random protocol run
        for (int c = 0; c < 10000; c++) begin
            rand_step(1'b1);
        end
        n = 0;
        while ((mem_if.req0 || mem_if.req1) && n < 200) begin
            rand_step(1'b0);
            n++;
        end
        check("rand_viol", 32'(viol), 0);
        check("rand_spurious", 32'(spurious), 0);
        check("rand_acks0", 32'(acked0), 32'(raised0));
        check("rand_acks1", 32'(acked1), 32'(raised1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter M, 16, data bus width.
REQ-002 Parameter N, 32, address bus width.
REQ-003 Parameter TIMEOUT, 255, max cycles waiting for memAck before abort (1..255).
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Ports req0/req1  input  1  access request from requester 0/1; held high until its ack.
REQ-007 Ports addr0/addr1  input  N  access address.
REQ-008 Ports wdata0/wdata1  input  M  write data.
REQ-009 Ports we0/we1  input  1  1 = write, 0 = read.
REQ-010 Ports ack0/ack1  output  1  one-cycle completion pulse to requester 0/1.
REQ-011 Port err  output  1  one-cycle pulse, coincident with the ack of an aborted (timed-out) access.
REQ-012 Port rdata  output  M  read data, valid while ack0 or ack1 is high.
REQ-013 Ports memAddr  output  N, memWrite  output  M  memory address and write data.
REQ-014 Ports memRE/memWE  output  1  memory read/write strobes.
REQ-015 Port memRead  input  M  memory read data, valid with memAck.
REQ-016 Port memAck  input  1  memory completion; sampled only in BUSY.

Function
REQ-017 FSM states IDLE, BUSY, DONE; all outputs registered.
REQ-018 IDLE: no req -> stay IDLE; any req -> select winner, latch its addr/wdata/we and the owner id, go BUSY.
REQ-019 BUSY: memAddr/memWrite = latched values; memRE = !we, memWE = we, held constant for the whole of BUSY.
REQ-020 BUSY with memAck=1 -> DONE; rdata <= memRead on a read (unchanged on a write); strobes drop at the same edge.
REQ-021 DONE lasts exactly one cycle: ack of the owner = 1, other ack = 0; reqs ignored; next state IDLE.
REQ-022 Latency: req sampled at edge k -> strobes high from edge k+1; memAck sampled at edge j -> ack high from edge j+1 for one cycle; minimum 3 cycles per access.
REQ-023 Timeout counter cleared on entry to BUSY and incremented each BUSY cycle without memAck; reaching TIMEOUT -> DONE with err=1, strobes dropped, rdata unchanged.
REQ-024 memAck in the same cycle the counter reaches TIMEOUT -> normal completion, err=0.
REQ-025 memAck outside BUSY is ignored.
REQ-026 Request changes while BUSY or DONE have no effect on the current access.
REQ-027 Single requester: granted regardless of history.
REQ-028 Simultaneous req0 and req1: winner per REQ-033/034; loser waits, holding req.
REQ-029 Never more than one of ack0/ack1 high; never memRE and memWE both high.

Reset
REQ-030 rst high at an edge -> IDLE; memRE=memWE=ack0=ack1=err=0; memAddr=0, memWrite=0, rdata=0; timeout counter=0; last-owner=1.
REQ-031 rst during BUSY or DONE aborts the access: no ack or err is issued for it, and strobes are low from the following cycle.

Configuration
REQ-032 Macro MEM_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-033 Defined: on contention, grant goes to the requester that was not the last owner; last-owner is updated on each grant.
REQ-034 Undefined: fixed priority, requester 0 always wins contention; last-owner register is absent.

Verification
REQ-035 Read: req0=1, we0=0, addr0=0x00001234; memory acks 2 cycles into BUSY with memRead=0xBEEF -> memRE high 2 cycles with memAddr=0x00001234; ack0 one cycle with rdata=0xBEEF; err=0.
REQ-036 Write: req1=1, we1=1, addr1=0x0000D000, wdata1=0x5A5A; memAck in first BUSY cycle -> memWE one cycle with memWrite=0x5A5A; ack1 one cycle; rdata unchanged.
REQ-037 Contention: req0 and req1 held high for 4 accesses -> with MEM_ARB_ROUND_ROBIN_EN grants are 0,1,0,1; without it grants are 0,0,0,0 while req0 stays high.
REQ-038 Timeout: TIMEOUT=4, memAck never asserted -> strobes high exactly 4 cycles, then ack0=1 and err=1 for one cycle, then IDLE.
REQ-039 Reset mid-access: rst pulsed in the 2nd BUSY cycle -> strobes low next cycle, no ack or err, all outputs at reset values; next req0 is granted.
REQ-040 Protocol: random req and memAck stimulus for 10k cycles -> REQ-029 holds and each accepted request gets exactly one ack.
